// File: rtl/sipo_deserializer.sv
// sipo_deserializer: receive end of the PISO shift-register link.
// Reassembles framed serial bits into WIDTH-bit words and hands each word
// downstream through a one-entry valid/ready holding register. Dropped
// words and restarted frames are reported as one-cycle pulses.
module sipo_deserializer #(
   parameter int WIDTH     = 4,
   parameter bit LSB_FIRST = 1'b1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             sin,
   input  logic             sin_valid,
   input  logic             sin_start,
   output logic [WIDTH-1:0] pout,
   output logic             pout_valid,
   input  logic             pout_ready,
   output logic             busy,
   output logic             overrun,
   output logic             frame_err
);

   localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);

   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] sr_q, sr_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] pout_q, pout_d;
   logic             pout_valid_q, pout_valid_d;
   logic             overrun_q, overrun_d;
   logic             frame_err_q, frame_err_d;
   logic [WIDTH-1:0] sr_ins;
   logic             word_done;

   // The shift direction decides where the first bit of a frame ends up.
   generate
      if (LSB_FIRST) begin : g_lsb_first
         assign sr_ins = {sin, sr_q[WIDTH-1:1]};
      end else begin : g_msb_first
         assign sr_ins = {sr_q[WIDTH-2:0], sin};
      end
   endgenerate

   // Frame tracking, word completion and holding-register handshake.
   always_comb begin
      state_d      = state_q;
      sr_d         = sr_q;
      cnt_d        = cnt_q;
      pout_d       = pout_q;
      pout_valid_d = pout_valid_q;
      overrun_d    = 1'b0;
      frame_err_d  = 1'b0;
      word_done    = 1'b0;

      if (sin_valid) begin
         unique case (state_q)
            IDLE: begin
               if (sin_start) begin
                  sr_d    = sr_ins;
                  cnt_d   = CNT_ONE;
                  state_d = SHIFT;
               end
            end
            SHIFT: begin
               sr_d = sr_ins;
               if (sin_start) begin
                  frame_err_d = 1'b1;
                  cnt_d       = CNT_ONE;
               end else if (cnt_q == CNT_LAST) begin
                  word_done = 1'b1;
                  cnt_d     = '0;
                  state_d   = IDLE;
               end else begin
                  cnt_d = cnt_q + CNT_ONE;
               end
            end
            default: begin
               state_d = IDLE;
            end
         endcase
      end

      if (word_done) begin
         if (!pout_valid_q || pout_ready) begin
            pout_d       = sr_ins;
            pout_valid_d = 1'b1;
         end else begin
            overrun_d = 1'b1;
         end
      end else if (pout_valid_q && pout_ready) begin
         pout_valid_d = 1'b0;
      end
   end

   // State registers; reset abandons any partial frame silently.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         sr_q         <= '0;
         cnt_q        <= '0;
         pout_q       <= '0;
         pout_valid_q <= 1'b0;
         overrun_q    <= 1'b0;
         frame_err_q  <= 1'b0;
      end else begin
         state_q      <= state_d;
         sr_q         <= sr_d;
         cnt_q        <= cnt_d;
         pout_q       <= pout_d;
         pout_valid_q <= pout_valid_d;
         overrun_q    <= overrun_d;
         frame_err_q  <= frame_err_d;
      end
   end

   assign pout       = pout_q;
   assign pout_valid = pout_valid_q;
   assign busy       = (state_q == SHIFT);
   assign overrun    = overrun_q;
   assign frame_err  = frame_err_q;

endmodule

// File: tb/tb_sipo_deserializer.sv
// tb_sipo_deserializer: drives three receivers (4-bit LSB-first, 4-bit
// MSB-first, 2-bit LSB-first) from one serial stream and scoreboards them
// against a frame-level model of the link.
module tb_sipo_deserializer;

   localparam int NDUT = 3;
   localparam int W_OF [NDUT] = '{4, 4, 2};
   localparam bit L_OF [NDUT] = '{1'b1, 1'b0, 1'b1};

   typedef struct packed {
      logic [NDUT-1:0] busy;
      logic [NDUT-1:0] ovr;
      logic [NDUT-1:0] fe;
      logic [NDUT-1:0] pv;
   } cyc_exp_t;

   logic            clk;
   logic            rst_n;
   logic            sin;
   logic            sin_valid;
   logic            sin_start;
   logic            pout_ready;
   logic [3:0]      pout_a;
   logic [3:0]      pout_b;
   logic [1:0]      pout_c;
   logic [NDUT-1:0] pv;
   logic [NDUT-1:0] busy;
   logic [NDUT-1:0] ovr;
   logic [NDUT-1:0] fe;

   int errors = 0;
   int checks = 0;

   cyc_exp_t   cyc_q[$];
   logic [3:0] word_q0[$];
   logic [3:0] word_q1[$];
   logic [3:0] word_q2[$];
   bit         mon_en = 1'b0;

   // Frame-level reference model state
   bit         m_in_frame [NDUT];
   int         m_len      [NDUT];
   logic [3:0] m_bits     [NDUT];
   bit         m_hv       [NDUT];

   sipo_deserializer #(.WIDTH(4), .LSB_FIRST(1'b1)) u_lsb4 (
      .clk(clk), .rst_n(rst_n), .sin(sin), .sin_valid(sin_valid), .sin_start(sin_start),
      .pout(pout_a), .pout_valid(pv[0]), .pout_ready(pout_ready), .busy(busy[0]),
      .overrun(ovr[0]), .frame_err(fe[0]));

   sipo_deserializer #(.WIDTH(4), .LSB_FIRST(1'b0)) u_msb4 (
      .clk(clk), .rst_n(rst_n), .sin(sin), .sin_valid(sin_valid), .sin_start(sin_start),
      .pout(pout_b), .pout_valid(pv[1]), .pout_ready(pout_ready), .busy(busy[1]),
      .overrun(ovr[1]), .frame_err(fe[1]));

   sipo_deserializer #(.WIDTH(2), .LSB_FIRST(1'b1)) u_lsb2 (
      .clk(clk), .rst_n(rst_n), .sin(sin), .sin_valid(sin_valid), .sin_start(sin_start),
      .pout(pout_c), .pout_valid(pv[2]), .pout_ready(pout_ready), .busy(busy[2]),
      .overrun(ovr[2]), .frame_err(fe[2]));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [3:0] act, input logic [3:0] expv);
      checks++;
      if (act !== expv) begin
         errors++;
         $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, expv, $time);
      end
   endtask

   function automatic logic [3:0] poutOf(input int d);
      logic [3:0] r;
      r = '0;
      case (d)
         0:       r = pout_a;
         1:       r = pout_b;
         default: r = {2'b00, pout_c};
      endcase
      return r;
   endfunction

   task automatic pushWord(input int d, input logic [3:0] w);
      case (d)
         0:       word_q0.push_back(w);
         1:       word_q1.push_back(w);
         default: word_q2.push_back(w);
      endcase
   endtask

   task automatic modelClear();
      for (int d = 0; d < NDUT; d++) begin
         m_in_frame[d] = 1'b0;
         m_len[d]      = 0;
         m_bits[d]     = '0;
         m_hv[d]       = 1'b0;
      end
      cyc_q.delete();
      word_q0.delete();
      word_q1.delete();
      word_q2.delete();
   endtask

   // Frame-level model: collect bits of the current frame, form the word
   // once WIDTH bits have arrived, then apply the holding-register rules.
   task automatic modelStep(input logic v, input logic s, input logic b, input logic r);
      cyc_exp_t   e;
      logic       completed;
      logic [3:0] word;
      e = '0;
      for (int d = 0; d < NDUT; d++) begin
         completed = 1'b0;
         word      = '0;
         if (v) begin
            if (s) begin
               if (m_in_frame[d]) e.fe[d] = 1'b1;
               m_in_frame[d] = 1'b1;
               m_len[d]      = 0;
            end
            if (m_in_frame[d]) begin
               m_bits[d][m_len[d]] = b;
               m_len[d]++;
               if (m_len[d] == W_OF[d]) begin
                  for (int i = 0; i < W_OF[d]; i++) begin
                     if (L_OF[d]) word[i] = m_bits[d][i];
                     else         word[W_OF[d]-1-i] = m_bits[d][i];
                  end
                  completed     = 1'b1;
                  m_in_frame[d] = 1'b0;
                  m_len[d]      = 0;
               end
            end
         end
         if (completed) begin
            if (!m_hv[d] || r) begin
               m_hv[d] = 1'b1;
               pushWord(d, word);
            end else begin
               e.ovr[d] = 1'b1;
            end
         end else if (m_hv[d] && r) begin
            m_hv[d] = 1'b0;
         end
         e.busy[d] = m_in_frame[d];
         e.pv[d]   = m_hv[d];
      end
      cyc_q.push_back(e);
   endtask

   task automatic applyStimulus(input logic v, input logic s, input logic b, input logic r);
      @(negedge clk);
      sin_valid  = v;
      sin_start  = s;
      sin        = b;
      pout_ready = r;
      modelStep(v, s, b, r);
   endtask

   task automatic sendFrame(input logic [3:0] bits, input int n, input logic r);
      for (int i = 0; i < n; i++) applyStimulus(1'b1, i == 0, bits[i], r);
   endtask

   task automatic checkAllZero(input string tag);
      checkOutput({tag, "_pv"},    4'(pv),    4'h0);
      checkOutput({tag, "_busy"},  4'(busy),  4'h0);
      checkOutput({tag, "_ovr"},   4'(ovr),   4'h0);
      checkOutput({tag, "_fe"},    4'(fe),    4'h0);
      checkOutput({tag, "_pouta"}, pout_a,    4'h0);
      checkOutput({tag, "_poutb"}, pout_b,    4'h0);
      checkOutput({tag, "_poutc"}, 4'(pout_c), 4'h0);
   endtask

   // Assert reset between clock edges, optionally toggle inputs while held.
   task automatic doReset(input int hold_cycles);
      @(negedge clk);
      mon_en = 1'b0;
      #2;
      rst_n = 1'b0;
      #1;
      checkAllZero("rst_immediate");
      for (int c = 0; c < hold_cycles; c++) begin
         @(negedge clk);
         sin_valid  = 1'($urandom);
         sin_start  = 1'($urandom);
         sin        = 1'($urandom);
         pout_ready = 1'($urandom);
         @(posedge clk);
         #2;
         checkAllZero("rst_held");
      end
      @(negedge clk);
      sin_valid  = 1'b0;
      sin_start  = 1'b0;
      sin        = 1'b0;
      pout_ready = 1'b0;
      rst_n      = 1'b1;
      modelClear();
      mon_en     = 1'b1;
   endtask

   // Monitor: one expectation per clock for status outputs, plus the word
   // scoreboard whenever a receiver presents a newly loaded word.
   initial begin : monitor
      cyc_exp_t   e;
      logic [3:0] expw;
      logic [3:0] last_w [NDUT];
      logic       prev_pv [NDUT];
      logic       new_word;
      for (int d = 0; d < NDUT; d++) begin
         last_w[d]  = '0;
         prev_pv[d] = 1'b0;
      end
      forever begin
         @(posedge clk);
         #2;
         if (!mon_en) begin
            for (int d = 0; d < NDUT; d++) prev_pv[d] = 1'b0;
         end else if (cyc_q.size() > 0) begin
            e = cyc_q.pop_front();
            for (int d = 0; d < NDUT; d++) begin
               checkOutput($sformatf("busy%0d", d),      4'(busy[d]), 4'(e.busy[d]));
               checkOutput($sformatf("overrun%0d", d),   4'(ovr[d]),  4'(e.ovr[d]));
               checkOutput($sformatf("frame_err%0d", d), 4'(fe[d]),   4'(e.fe[d]));
               checkOutput($sformatf("pout_valid%0d", d), 4'(pv[d]),  4'(e.pv[d]));
               new_word = pv[d] && (!prev_pv[d] || pout_ready);
               if (new_word) begin
                  expw = 'x;
                  case (d)
                     0: if (word_q0.size() > 0) expw = word_q0.pop_front();
                     1: if (word_q1.size() > 0) expw = word_q1.pop_front();
                     default: if (word_q2.size() > 0) expw = word_q2.pop_front();
                  endcase
                  if ($isunknown(expw)) begin
                     checks++;
                     errors++;
                     $display("[TB] FAIL word%0d: got %h, expected no word at %0t", d, poutOf(d), $time);
                  end else begin
                     checkOutput($sformatf("word%0d", d), poutOf(d), expw);
                     last_w[d] = expw;
                  end
               end else if (pv[d]) begin
                  checkOutput($sformatf("hold%0d", d), poutOf(d), last_w[d]);
               end
               prev_pv[d] = pv[d];
            end
         end
      end
   end

   // Stimulus: directed scenarios followed by randomized traffic.
   initial begin : stimulus
      rst_n      = 1'b0;
      sin        = 1'b0;
      sin_valid  = 1'b0;
      sin_start  = 1'b0;
      pout_ready = 1'b0;
      modelClear();

      doReset(3);

      $display("[TB] bits without start");
      for (int i = 0; i < 5; i++) applyStimulus(1'b1, 1'b0, 1'($urandom), 1'b1);

      $display("[TB] basic frames");
      sendFrame(4'b1001, 4, 1'b1);
      sendFrame(4'b0011, 4, 1'b1);
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);

      $display("[TB] gaps mid-frame");
      applyStimulus(1'b1, 1'b1, 1'b1, 1'b1);
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b1);
      for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0, 1'($urandom), 1'b1);
      applyStimulus(1'b1, 1'b0, 1'b1, 1'b1);
      applyStimulus(1'b1, 1'b0, 1'b1, 1'b1);
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);

      $display("[TB] overrun");
      sendFrame(4'b0110, 4, 1'b0);
      sendFrame(4'b1110, 4, 1'b0);
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);

      $display("[TB] restart mid-frame");
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b1);
      applyStimulus(1'b1, 1'b0, 1'b1, 1'b1);
      sendFrame(4'b1101, 4, 1'b1);
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);

      $display("[TB] async reset mid-frame");
      applyStimulus(1'b1, 1'b1, 1'b1, 1'b1);
      applyStimulus(1'b1, 1'b0, 1'b1, 1'b1);
      doReset(0);
      sendFrame(4'b0101, 4, 1'b1);
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);

      $display("[TB] random traffic");
      for (int i = 0; i < 400; i++) begin
         applyStimulus(($urandom_range(3) != 0), ($urandom_range(5) == 0),
                       1'($urandom), ($urandom_range(9) < 7));
      end

      for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
      @(posedge clk);
      #3;
      checkOutput("leftover_cycles", 4'(cyc_q.size()),   4'h0);
      checkOutput("leftover_words0", 4'(word_q0.size()), 4'h0);
      checkOutput("leftover_words1", 4'(word_q1.size()), 4'h0);
      checkOutput("leftover_words2", 4'(word_q2.size()), 4'h0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/sipo_deserializer.md
# sipo_deserializer

Serial-in, parallel-out receiver that reassembles WIDTH-bit words from a framed serial bit stream. It is the receive end of the team's PISO shift-register link. Each completed word is handed to downstream logic through a one-entry valid/ready holding register, and overrun and framing errors are reported as one-cycle pulses.

## Interface
Parameters:
- WIDTH, 4, bits per word; must be ≥ 2.
- LSB_FIRST, 1, 1: the first received bit lands in pout[0]; 0: the first received bit lands in pout[WIDTH-1].

Ports:
- clk  input  1  single clock; all logic is rising-edge.
- rst_n  input  1  asynchronous, active-low reset.
- sin  input  1  serial data bit.
- sin_valid  input  1  sin is sampled on this edge.
- sin_start  input  1  qualified by sin_valid; marks the current bit as bit 0 of a new frame.
- pout  output  WIDTH  assembled word (holding register).
- pout_valid  output  1  pout holds an unconsumed word.
- pout_ready  input  1  downstream accepts pout this cycle.
- busy  output  1  a frame is partially received (state SHIFT).
- overrun  output  1  one-cycle pulse: a completed word was dropped.
- frame_err  output  1  one-cycle pulse: a frame was restarted before completion.

## Operation
- Internal state: shift register sr[WIDTH-1:0], bit counter cnt (0..WIDTH-1, width clog2(WIDTH)), FSM {IDLE, SHIFT}.
- Insert rule:
  - LSB_FIRST=1: sr_next = {sin, sr[WIDTH-1:1]}.
  - LSB_FIRST=0: sr_next = {sr[WIDTH-2:0], sin}.
  - After WIDTH inserts, the first bit sits at pout[0] (LSB_FIRST=1) or pout[WIDTH-1] (LSB_FIRST=0).
- IDLE:
  - sin_valid && sin_start: insert bit, cnt←1, go to SHIFT.
  - sin_valid without sin_start: bit ignored.
- SHIFT, on sin_valid && !sin_start:
  - Insert bit, cnt←cnt+1.
  - If this was bit WIDTH-1 (cnt==WIDTH-1 before the edge): word completes, cnt←0, go to IDLE.
- SHIFT, on sin_valid && sin_start:
  - Partial frame discarded; frame_err pulses.
  - The bit is inserted as bit 0 of the new frame, cnt←1, stay in SHIFT.
- Word completion, on the completing edge:
  - If holding is empty, or pout_ready is high that cycle: pout←sr_next, pout_valid←1.
  - Else (pout_valid && !pout_ready): word dropped, pout unchanged, overrun pulses.
- Drain: pout_valid && pout_ready with no completion that cycle → pout_valid←0; pout keeps its last value.
- sin_valid low: no state change; gaps between bits are allowed anywhere in a frame.
- busy = (state == SHIFT).

## Timing
- Reset (rst_n low, asynchronous): sr=0, cnt=0, state=IDLE, pout=0, pout_valid=0, busy=0, overrun=0, frame_err=0.
- Reset mid-frame: the partial frame is lost, and no frame_err is raised for it.
- Latency: pout/pout_valid update on the same edge that samples the last bit, so they are visible one cycle after the last sin_valid cycle.
- Back-to-back frames:
  - A new frame's sin_start is accepted on the edge immediately after completion (IDLE accepts it).
  - Throughput is 1 word per WIDTH valid cycles.
- Simultaneous completion and pout_ready: old word consumed and new word loaded on the same edge; pout_valid stays 1 and there is no overrun.
- overrun and frame_err are registered, high for exactly one cycle, and asserted the cycle after the causing edge.
- pout_ready while pout_valid=0: ignored.
- WIDTH=2 boundary: a frame is sin_start plus one more bit; the counter must not wrap incorrectly.

## Test plan
- Reset: hold rst_n low, toggle inputs → all outputs 0, busy=0. Release, then send bits without sin_start → no pout_valid.
- LSB_FIRST=1, WIDTH=4, send bits 1,0,0,1 (start on the first), pout_ready=1 → pout=4'b1001, pout_valid high one cycle after the 4th bit. Repeat with bits 1,1,0,0 → pout=4'b0011. With LSB_FIRST=0, bits 1,1,0,0 → 4'b1100.
- Gaps: sin_valid low for 3 cycles between bits 2 and 3 → same word as without gaps; busy high throughout the gap.
- Overrun: pout_ready=0, send two full frames back to back → first word held in pout, overrun pulses once after the second frame; raise pout_ready → first word drains, pout_valid=0.
- Restart: after 2 bits, assert sin_start with new bit 0 → frame_err pulses once; the following 3 bits complete a word built from the new frame only.
- Async reset: assert rst_n mid-frame (after 2 bits, between clock edges) → outputs clear immediately. A new full frame then yields the correct word with no frame_err.
